key_event_controller: RTL

KEY_EVENT_CONTROLLER -- requirements
Module: key_event_controller

---
 rtl/key_event_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/key_event_controller.sv
`default_nettype none
// ============================================================================
// key_event_controller: debounced pushbutton press detector, Avalon-MM regs.
// Revision: 1.0
// ============================================================================
module key_event_controller #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync;
  logic [NUM_KEYS-1:0] state;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] mask;
  logic [NUM_KEYS-1:0] edge_flags;
  logic [NUM_KEYS-1:0] edge_clear;
  logic [15:0]         event_count;
  logic [15:0]         press_count;
  logic                wr_en;
  logic                unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:NUM_KEYS];

  // Flops hold the inverted level so reset means "not pressed".
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= ~key_n;
      sync      <= sync_meta;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [CW-1:0] cnt;
    logic          level;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync[i] == level) begin
        cnt   <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync[i];
      end else begin
        cnt   <= cnt + CW'(1);
      end
    end

    assign state[i] = level;
    assign press[i] = sync[i] & ~level & (cnt == CNT_MAX);
  end

  always_comb begin
    press_count = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_count = press_count + 16'(press[i]);
    end
  end

  assign edge_clear = (wr_en && address == 2'd2) ? writedata[NUM_KEYS-1:0] : '0;

  // Setting is ORed in after the clear so a coincident press survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask        <= '0;
      edge_flags  <= '0;
      event_count <= '0;
    end else begin
      if (wr_en && address == 2'd1) begin
        mask <= writedata[NUM_KEYS-1:0];
      end
      edge_flags <= (edge_flags & ~edge_clear) | press;
      if (wr_en && address == 2'd3) begin
        event_count <= press_count;
      end else begin
        event_count <= event_count + press_count;
      end
    end
  end

  assign irq = |(edge_flags & mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(state);
        2'd1:    readdata <= 32'(mask);
        2'd2:    readdata <= 32'(edge_flags);
        default: readdata <= {irq, 15'd0, event_count};
      endcase
    end
  end

endmodule
`default_nettype wire
